tanimoto_run_ctrl: RTL and testbench

Run-level sequencer for the tanimoto_top accelerator pipeline. It loads a per-run set of comparator thresholds into the comparator BRAM from a config stream, then opens the vector data stream to the pipeline. It closes the data stream on tlast and waits for the final ID pair to leave the output stream before signalling completion. It sits between the host-side AXI streams and tanimoto_top, and owns the BRAM write port and the input-stream gate.

---
 rtl/tanimoto_ctrl_pkg.sv | 13 +
 rtl/tanimoto_run_ctrl.sv | 93 +++++++++
 tb/tb_tanimoto_run_ctrl.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/tanimoto_ctrl_pkg.sv
// tanimoto_ctrl_pkg: shared state encodings and width helpers for the tanimoto run controller
package tanimoto_ctrl_pkg;
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_STREAM = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;
  function automatic int thr_cnt_width(input int thr_max);
    return $clog2(thr_max + 1);
  endfunction
endpackage

// File: rtl/tanimoto_run_ctrl.sv
// tanimoto_run_ctrl: loads per-run thresholds into the comparator BRAM, gates the vector stream, waits for the last ID pair
module tanimoto_run_ctrl
  import tanimoto_ctrl_pkg::*;
#(
  parameter int VECTOR_WIDTH   = 920,
  parameter int CNT_WIDTH      = $clog2(VECTOR_WIDTH),
  parameter int THR_MAX        = 16,
  parameter int BEAT_CNT_WIDTH = 24,
  localparam int THR_W         = thr_cnt_width(THR_MAX)
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst,
  input  logic                      i_Start,
  input  logic [THR_W-1:0]          i_ThrCount,
  input  logic [CNT_WIDTH-1:0]      S_AXIS_THR_tdata,
  input  logic                      S_AXIS_THR_tvalid,
  output logic                      S_AXIS_THR_tready,
  output logic [CNT_WIDTH-1:0]      o_BRAM_Addr,
  output logic [CNT_WIDTH-1:0]      o_BRAM_Din,
  output logic                      o_BRAM_En,
  output logic                      o_BRAM_WrEn,
  input  logic                      S_AXIS_DATA_tvalid,
  input  logic                      S_AXIS_DATA_tlast,
  output logic                      S_AXIS_DATA_tready,
  output logic                      o_Valid,
  input  logic                      i_Read,
  input  logic                      M_AXIS_ID_PAIR_tvalid,
  input  logic                      M_AXIS_ID_PAIR_tready,
  input  logic                      M_AXIS_ID_PAIR_tlast,
  output logic                      o_Busy,
  output logic                      o_Done,
  output logic [BEAT_CNT_WIDTH-1:0] o_BeatCount
);
  state_t state, next;
  logic [THR_W-1:0] cnt, idx, start_cnt;
  logic seen, in_stream, thr_hs, data_hs, id_last, start;
  assign start_cnt = (i_ThrCount > THR_W'(THR_MAX)) ? THR_W'(THR_MAX) : i_ThrCount;
  assign start = (state == ST_IDLE) && i_Start;
  assign in_stream = state == ST_STREAM;
  assign S_AXIS_THR_tready = state == ST_LOAD;
  assign S_AXIS_DATA_tready = in_stream && i_Read;
  assign o_Valid = in_stream && S_AXIS_DATA_tvalid;
  assign o_Done = state == ST_DONE;
  assign thr_hs = S_AXIS_THR_tvalid && S_AXIS_THR_tready;
  assign data_hs = in_stream && S_AXIS_DATA_tvalid && i_Read;
  assign id_last = M_AXIS_ID_PAIR_tvalid && M_AXIS_ID_PAIR_tready && M_AXIS_ID_PAIR_tlast;
  always_ff @(posedge ap_clk) begin
    if (ap_rst) state <= ST_IDLE;
    else state <= next;
  end
  // The ID-pair tlast may leave before the data tlast, so DRAIN also honours the sticky flag.
  always_comb begin
    next = state;
    case (state)
      ST_IDLE:   next = i_Start ? ((start_cnt != '0) ? ST_LOAD : ST_STREAM) : ST_IDLE;
      ST_LOAD:   next = (thr_hs && idx == cnt - THR_W'(1)) ? ST_STREAM : ST_LOAD;
      ST_STREAM: next = (data_hs && S_AXIS_DATA_tlast) ? ST_DRAIN : ST_STREAM;
      ST_DRAIN:  next = (seen || id_last) ? ST_DONE : ST_DRAIN;
      default:   next = ST_IDLE;
    endcase
  end
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      o_Busy      <= 1'b0;
      o_BRAM_En   <= 1'b0;
      o_BRAM_WrEn <= 1'b0;
      o_BRAM_Addr <= '0;
      o_BRAM_Din  <= '0;
      o_BeatCount <= '0;
      cnt         <= '0;
      idx         <= '0;
      seen        <= 1'b0;
    end else begin
      o_Busy      <= state != ST_IDLE;
      o_BRAM_En   <= thr_hs;
      o_BRAM_WrEn <= thr_hs;
      if (thr_hs) begin
        o_BRAM_Addr <= CNT_WIDTH'(idx);
        o_BRAM_Din  <= S_AXIS_THR_tdata;
        idx         <= idx + THR_W'(1);
      end
      if (start) begin
        cnt         <= start_cnt;
        idx         <= '0;
        seen        <= 1'b0;
        o_BeatCount <= '0;
      end else begin
        if (state != ST_IDLE && id_last) seen <= 1'b1;
        if (data_hs && !(&o_BeatCount)) o_BeatCount <= o_BeatCount + BEAT_CNT_WIDTH'(1);
      end
    end
  end
endmodule

// File: tb/tb_tanimoto_run_ctrl.sv
// tb_tanimoto_run_ctrl: vector table, directed corner sequences and randomized runs against a phase-level run model
module tb_tanimoto_run_ctrl;
  localparam int THR_MAX = 16;
  logic ap_clk = 1'b0;
  logic ap_rst, i_Start, S_AXIS_THR_tvalid, S_AXIS_THR_tready, o_BRAM_En, o_BRAM_WrEn;
  logic [4:0] i_ThrCount;
  logic [9:0] S_AXIS_THR_tdata, o_BRAM_Addr, o_BRAM_Din;
  logic S_AXIS_DATA_tvalid, S_AXIS_DATA_tlast, S_AXIS_DATA_tready, o_Valid, i_Read;
  logic M_AXIS_ID_PAIR_tvalid, M_AXIS_ID_PAIR_tready, M_AXIS_ID_PAIR_tlast, o_Busy, o_Done;
  logic [23:0] o_BeatCount;
  int checks = 0, failures = 0;
  bit prev_ni = 0;

  tanimoto_run_ctrl dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .i_Start(i_Start), .i_ThrCount(i_ThrCount),
    .S_AXIS_THR_tdata(S_AXIS_THR_tdata), .S_AXIS_THR_tvalid(S_AXIS_THR_tvalid),
    .S_AXIS_THR_tready(S_AXIS_THR_tready), .o_BRAM_Addr(o_BRAM_Addr), .o_BRAM_Din(o_BRAM_Din),
    .o_BRAM_En(o_BRAM_En), .o_BRAM_WrEn(o_BRAM_WrEn), .S_AXIS_DATA_tvalid(S_AXIS_DATA_tvalid),
    .S_AXIS_DATA_tlast(S_AXIS_DATA_tlast), .S_AXIS_DATA_tready(S_AXIS_DATA_tready),
    .o_Valid(o_Valid), .i_Read(i_Read), .M_AXIS_ID_PAIR_tvalid(M_AXIS_ID_PAIR_tvalid),
    .M_AXIS_ID_PAIR_tready(M_AXIS_ID_PAIR_tready), .M_AXIS_ID_PAIR_tlast(M_AXIS_ID_PAIR_tlast),
    .o_Busy(o_Busy), .o_Done(o_Done), .o_BeatCount(o_BeatCount)
  );

  always #5 ap_clk = ~ap_clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic st; logic [4:0] tc; logic tv; logic [9:0] td;
    logic dv, dl, rd, mv, mr, ml;
    logic e_tr, e_en; logic [9:0] e_a, e_d;
    logic e_dr, e_v, e_b, e_dn; logic [23:0] e_bc;
  } vec_t;
  vec_t tbl[$];

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic eoc(input bit ni);
    chk("busy", {31'd0, o_Busy}, {31'd0, prev_ni});
    prev_ni = ni;
    tick();
  endtask

  task automatic chk_wr(input bit pend, input logic [9:0] pa, input logic [9:0] pd);
    chk("bram_en", {31'd0, o_BRAM_En}, {31'd0, pend});
    chk("bram_wren", {31'd0, o_BRAM_WrEn}, {31'd0, pend});
    if (pend) begin
      chk("bram_addr", {22'd0, o_BRAM_Addr}, {22'd0, pa});
      chk("bram_din", {22'd0, o_BRAM_Din}, {22'd0, pd});
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".thr_tready"}, {31'd0, S_AXIS_THR_tready}, 0);
    chk({tag, ".bram_en"}, {31'd0, o_BRAM_En}, 0);
    chk({tag, ".bram_wren"}, {31'd0, o_BRAM_WrEn}, 0);
    chk({tag, ".bram_addr"}, {22'd0, o_BRAM_Addr}, 0);
    chk({tag, ".bram_din"}, {22'd0, o_BRAM_Din}, 0);
    chk({tag, ".data_tready"}, {31'd0, S_AXIS_DATA_tready}, 0);
    chk({tag, ".valid"}, {31'd0, o_Valid}, 0);
    chk({tag, ".busy"}, {31'd0, o_Busy}, 0);
    chk({tag, ".done"}, {31'd0, o_Done}, 0);
    chk({tag, ".beats"}, {8'd0, o_BeatCount}, 0);
  endtask

  task automatic m_set(input logic v, input logic r, input logic l);
    M_AXIS_ID_PAIR_tvalid = v;
    M_AXIS_ID_PAIR_tready = r;
    M_AXIS_ID_PAIR_tlast = l;
  endtask

  // One run: n thresholds requested, nb data beats, ID tlast either early (in STREAM) or dwait cycles into DRAIN.
  task automatic run(input int n, input int nb, input bit early, input int dwait, input bit gaps);
    int exp_n, k, sent, guard;
    bit pend;
    logic [9:0] pa, pd;
    exp_n = n > THR_MAX ? THR_MAX : n;
    i_Start = 1'b1;
    i_ThrCount = 5'(n);
    m_set(0, 0, 0);
    @(negedge ap_clk);
    chk("start.thr_tready", {31'd0, S_AXIS_THR_tready}, 0);
    chk("start.done", {31'd0, o_Done}, 0);
    eoc(0);
    i_Start = 1'b0;
    pend = 0; pa = '0; pd = '0; k = 0; guard = 0;
    while (k < exp_n && guard < 400) begin
      S_AXIS_THR_tvalid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      S_AXIS_THR_tdata = 10'($urandom);
      @(negedge ap_clk);
      chk("load.thr_tready", {31'd0, S_AXIS_THR_tready}, 1);
      chk("load.data_tready", {31'd0, S_AXIS_DATA_tready}, 0);
      chk_wr(pend, pa, pd);
      pend = S_AXIS_THR_tvalid;
      pa = 10'(k);
      pd = S_AXIS_THR_tdata;
      if (pend) k++;
      guard++;
      eoc(1);
    end
    if (guard >= 400) begin
      checks++; failures++;
      $display("FAIL load_timeout: got %0d writes expected %0d", k, exp_n);
    end
    S_AXIS_THR_tvalid = 1'b1;
    sent = 0; guard = 0;
    while (sent < nb && guard < 400) begin
      S_AXIS_DATA_tvalid = 1'($urandom_range(0, 1));
      S_AXIS_DATA_tlast = sent == nb - 1;
      i_Read = 1'($urandom_range(0, 1));
      i_Start = $urandom_range(0, 3) == 0;
      i_ThrCount = 5'($urandom);
      if (early && guard == 0) m_set(1, 1, 1);
      else m_set(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
      @(negedge ap_clk);
      chk("stream.valid", {31'd0, o_Valid}, {31'd0, S_AXIS_DATA_tvalid});
      chk("stream.data_tready", {31'd0, S_AXIS_DATA_tready}, {31'd0, i_Read});
      chk("stream.thr_tready", {31'd0, S_AXIS_THR_tready}, 0);
      chk("stream.done", {31'd0, o_Done}, 0);
      chk("stream.beats", {8'd0, o_BeatCount}, sent);
      chk_wr(pend, pa, pd);
      pend = 0;
      if (S_AXIS_DATA_tvalid && i_Read) sent++;
      guard++;
      eoc(1);
    end
    if (guard >= 400) begin
      checks++; failures++;
      $display("FAIL stream_timeout: got %0d beats expected %0d", sent, nb);
    end
    i_Start = 1'b0;
    S_AXIS_DATA_tvalid = 1'b1;
    S_AXIS_DATA_tlast = 1'b0;
    i_Read = 1'b1;
    for (int j = 0; j < (early ? 1 : dwait + 1); j++) begin
      if (!early && j == dwait) m_set(1, 1, 1);
      else m_set(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
      @(negedge ap_clk);
      chk("drain.done", {31'd0, o_Done}, 0);
      chk("drain.valid", {31'd0, o_Valid}, 0);
      chk("drain.data_tready", {31'd0, S_AXIS_DATA_tready}, 0);
      chk("drain.beats", {8'd0, o_BeatCount}, nb);
      eoc(1);
    end
    m_set(0, 0, 0);
    S_AXIS_DATA_tvalid = 1'b0;
    i_Read = 1'b0;
    i_Start = 1'b1;
    i_ThrCount = 5'($urandom);
    @(negedge ap_clk);
    chk("done.pulse", {31'd0, o_Done}, 1);
    chk("done.beats", {8'd0, o_BeatCount}, nb);
    eoc(1);
    i_Start = 1'b0;
    @(negedge ap_clk);
    chk("post.done", {31'd0, o_Done}, 0);
    chk("post.thr_tready", {31'd0, S_AXIS_THR_tready}, 0);
    chk("post.beats", {8'd0, o_BeatCount}, nb);
    eoc(0);
    @(negedge ap_clk);
    chk("idle.done", {31'd0, o_Done}, 0);
    eoc(0);
  endtask

  initial begin
    ap_rst = 1'b1; i_Start = 0; i_ThrCount = '0; S_AXIS_THR_tdata = '0; S_AXIS_THR_tvalid = 0;
    S_AXIS_DATA_tvalid = 0; S_AXIS_DATA_tlast = 0; i_Read = 0; m_set(0, 0, 0);
    repeat (3) tick();
    @(negedge ap_clk);
    chk_zero("reset");
    ap_rst = 1'b0;
    tick();

    // st tc tv td | dv dl rd mv mr ml | e_tr e_en e_a e_d | e_dr e_v e_b e_dn e_bc
    tbl.push_back('{1, 3, 0, 10'h000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 10'h000, 0, 0, 0, 0, 0});
    tbl.push_back('{0, 3, 1, 10'h005, 0, 0, 0, 0, 0, 0, 1, 0, 0, 10'h000, 0, 0, 0, 0, 0});
    tbl.push_back('{0, 3, 1, 10'h010, 0, 0, 0, 0, 0, 0, 1, 1, 0, 10'h005, 0, 0, 1, 0, 0});
    tbl.push_back('{0, 3, 1, 10'h03F, 0, 0, 0, 0, 0, 0, 1, 1, 1, 10'h010, 0, 0, 1, 0, 0});
    tbl.push_back('{0, 3, 1, 10'h02A, 1, 0, 1, 0, 0, 0, 0, 1, 2, 10'h03F, 1, 1, 1, 0, 0});
    tbl.push_back('{0, 3, 0, 10'h000, 1, 0, 0, 0, 0, 0, 0, 0, 0, 10'h000, 0, 1, 1, 0, 1});
    tbl.push_back('{0, 3, 0, 10'h000, 0, 0, 1, 0, 0, 0, 0, 0, 0, 10'h000, 1, 0, 1, 0, 1});
    tbl.push_back('{0, 3, 0, 10'h000, 1, 1, 1, 1, 1, 0, 0, 0, 0, 10'h000, 1, 1, 1, 0, 1});
    tbl.push_back('{0, 3, 0, 10'h000, 1, 0, 1, 1, 0, 1, 0, 0, 0, 10'h000, 0, 0, 1, 0, 2});
    tbl.push_back('{0, 3, 0, 10'h000, 0, 0, 0, 1, 1, 1, 0, 0, 0, 10'h000, 0, 0, 1, 0, 2});
    tbl.push_back('{1, 5, 0, 10'h000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 10'h000, 0, 0, 1, 1, 2});
    tbl.push_back('{0, 0, 0, 10'h000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 10'h000, 0, 0, 1, 0, 2});
    tbl.push_back('{1, 0, 0, 10'h000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 10'h000, 0, 0, 0, 0, 2});
    tbl.push_back('{0, 0, 1, 10'h001, 1, 0, 1, 0, 0, 0, 0, 0, 0, 10'h000, 1, 1, 0, 0, 0});
    tbl.push_back('{0, 0, 0, 10'h000, 1, 0, 1, 0, 0, 0, 0, 0, 0, 10'h000, 1, 1, 1, 0, 1});
    tbl.push_back('{0, 0, 0, 10'h000, 1, 0, 1, 0, 0, 0, 0, 0, 0, 10'h000, 1, 1, 1, 0, 2});
    tbl.push_back('{0, 0, 0, 10'h000, 1, 1, 1, 0, 0, 0, 0, 0, 0, 10'h000, 1, 1, 1, 0, 3});
    tbl.push_back('{0, 0, 0, 10'h000, 1, 0, 1, 0, 0, 0, 0, 0, 0, 10'h000, 0, 0, 1, 0, 4});
    tbl.push_back('{0, 0, 0, 10'h000, 0, 0, 0, 1, 1, 1, 0, 0, 0, 10'h000, 0, 0, 1, 0, 4});
    tbl.push_back('{0, 0, 0, 10'h000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 10'h000, 0, 0, 1, 1, 4});
    tbl.push_back('{0, 0, 0, 10'h000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 10'h000, 0, 0, 1, 0, 4});
    foreach (tbl[i]) begin
      i_Start = tbl[i].st; i_ThrCount = tbl[i].tc;
      S_AXIS_THR_tvalid = tbl[i].tv; S_AXIS_THR_tdata = tbl[i].td;
      S_AXIS_DATA_tvalid = tbl[i].dv; S_AXIS_DATA_tlast = tbl[i].dl; i_Read = tbl[i].rd;
      m_set(tbl[i].mv, tbl[i].mr, tbl[i].ml);
      @(negedge ap_clk);
      chk($sformatf("v%0d.thr_tready", i), {31'd0, S_AXIS_THR_tready}, {31'd0, tbl[i].e_tr});
      chk($sformatf("v%0d.bram_en", i), {31'd0, o_BRAM_En}, {31'd0, tbl[i].e_en});
      chk($sformatf("v%0d.bram_wren", i), {31'd0, o_BRAM_WrEn}, {31'd0, tbl[i].e_en});
      if (tbl[i].e_en) begin
        chk($sformatf("v%0d.bram_addr", i), {22'd0, o_BRAM_Addr}, {22'd0, tbl[i].e_a});
        chk($sformatf("v%0d.bram_din", i), {22'd0, o_BRAM_Din}, {22'd0, tbl[i].e_d});
      end
      chk($sformatf("v%0d.data_tready", i), {31'd0, S_AXIS_DATA_tready}, {31'd0, tbl[i].e_dr});
      chk($sformatf("v%0d.valid", i), {31'd0, o_Valid}, {31'd0, tbl[i].e_v});
      chk($sformatf("v%0d.busy", i), {31'd0, o_Busy}, {31'd0, tbl[i].e_b});
      chk($sformatf("v%0d.done", i), {31'd0, o_Done}, {31'd0, tbl[i].e_dn});
      chk($sformatf("v%0d.beats", i), {8'd0, o_BeatCount}, {8'd0, tbl[i].e_bc});
      tick();
    end
    i_Start = 0; S_AXIS_THR_tvalid = 0; S_AXIS_DATA_tvalid = 0; S_AXIS_DATA_tlast = 0; i_Read = 0;
    m_set(0, 0, 0);
    prev_ni = 0;

    // Reset in the middle of LOAD, right after the first write shows up.
    i_Start = 1'b1; i_ThrCount = 5'd3;
    tick();
    i_Start = 1'b0; S_AXIS_THR_tvalid = 1'b1; S_AXIS_THR_tdata = 10'h011;
    tick();
    S_AXIS_THR_tdata = 10'h022;
    @(negedge ap_clk);
    chk("rst_pre.bram_en", {31'd0, o_BRAM_En}, 1);
    chk("rst_pre.bram_addr", {22'd0, o_BRAM_Addr}, 0);
    chk("rst_pre.bram_din", {22'd0, o_BRAM_Din}, 10'h011);
    ap_rst = 1'b1;
    tick();
    ap_rst = 1'b0;
    @(negedge ap_clk);
    chk_zero("rst_post");
    tick();
    S_AXIS_THR_tvalid = 1'b0;
    prev_ni = 0;
    run(3, 2, 0, 1, 0);

    run(3, 4, 1, 0, 0);
    run(2, 3, 0, 10, 0);
    run(31, 2, 0, 0, 1);
    run(0, 1, 1, 0, 1);
    for (int r = 0; r < 14; r++)
      run($urandom_range(0, 20), $urandom_range(1, 8), 1'($urandom_range(0, 1)), $urandom_range(0, 12), 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
